// File: rtl/vie_sram_like_slave_if.sv
// vie_sram_like_slave_if: packed request/response buses between an SRAM-like initiator and responder
interface vie_sram_like_slave_if;
  logic [71:0] req_bus_i;
  logic [33:0] resp_bus_o;
  logic [2:0]  outstanding_o;
  modport master (output req_bus_i, input resp_bus_o, outstanding_o);
  modport slave (input req_bus_i, output resp_bus_o, outstanding_o);
endinterface

// File: rtl/vie_sram_like_slave.sv
// vie_sram_like_slave: SRAM-like responder with word memory, address-phase wait and in-order delayed responses
module vie_sram_like_slave #(
  parameter int MEM_AW   = 10,
  parameter int ADDR_LAT = 0,
  parameter int DATA_LAT = 1,
  parameter int DEPTH    = 2
) (
  input logic clock,
  input logic reset,
  vie_sram_like_slave_if.slave bus
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int WW = ADDR_LAT > 0 ? $clog2(ADDR_LAT + 1) : 1;
  logic              w_req, w_wr, w_full, w_aok, w_dok, w_unused;
  logic [3:0]        w_strb;
  logic [31:0]       w_addr, w_wdata, w_rdata;
  logic [MEM_AW-1:0] w_idx;
  logic [31:0]       r_mem [2**MEM_AW];
  logic              r_qwr [2**PW];
  logic [31:0]       r_qdat [2**PW];
  logic [3:0]        r_qage [2**PW];
  logic [PW-1:0]     r_head, r_tail;
  logic [2:0]        r_cnt;
  logic [WW-1:0]     r_wait;
  function automatic logic [PW-1:0] f_nxt(input logic [PW-1:0] p);
    return (int'(p) == DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign w_req    = bus.req_bus_i[71];
  assign w_wr     = bus.req_bus_i[70];
  assign w_strb   = bus.req_bus_i[67:64];
  assign w_addr   = bus.req_bus_i[63:32];
  assign w_wdata  = bus.req_bus_i[31:0];
  assign w_idx    = w_addr[MEM_AW+1:2];
  assign w_unused = ^{bus.req_bus_i[69:68], w_addr[31:MEM_AW+2], w_addr[1:0]};
  // A full queue blocks acceptance even when the head pops this cycle.
  assign w_full  = r_cnt == 3'(DEPTH);
  assign w_aok   = reset && w_req && !w_full && int'(r_wait) >= ADDR_LAT;
  assign w_dok   = r_cnt != 3'd0 && 5'(r_qage[r_head]) + 5'd1 >= 5'(DATA_LAT);
  assign w_rdata = (w_dok && !r_qwr[r_head]) ? r_qdat[r_head] : 32'h0;
  assign bus.resp_bus_o    = {w_aok, w_dok, w_rdata};
  assign bus.outstanding_o = r_cnt;
  // Byte-strobed memory write at the accept edge; contents survive reset.
  always_ff @(posedge clock)
    if (w_aok && w_wr)
      for (int i = 0; i < 4; i++)
        if (w_strb[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
  // Capture the pre-write word and request kind into the tail entry.
  always_ff @(posedge clock)
    if (w_aok) begin
      r_qwr[r_tail]  <= w_wr;
      r_qdat[r_tail] <= r_mem[w_idx];
    end
  // Queue pointers, occupancy, saturating ages and address-phase wait counter.
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= '0;
      r_wait <= '0;
      for (int i = 0; i < 2**PW; i++) r_qage[i] <= '0;
    end else begin
      for (int i = 0; i < 2**PW; i++) r_qage[i] <= (r_qage[i] == 4'hf) ? r_qage[i] : r_qage[i] + 4'd1;
      if (w_aok) r_qage[r_tail] <= '0;
      if (w_aok) r_tail <= f_nxt(r_tail);
      if (w_dok) r_head <= f_nxt(r_head);
      r_cnt  <= r_cnt + 3'(w_aok) - 3'(w_dok);
      r_wait <= (w_req && !w_aok) ? ((int'(r_wait) < ADDR_LAT) ? r_wait + 1'b1 : r_wait) : '0;
    end
endmodule

// File: tb/tb_vie_sram_like_slave.sv
// tb_vie_sram_like_slave: five differently configured slaves checked against a transaction-level model
module tb_vie_sram_like_slave;
  localparam int N = 5;
  localparam int AL [N] = '{0, 0, 2, 0, 1};
  localparam int DL [N] = '{1, 4, 1, 3, 15};
  localparam int DP [N] = '{2, 2, 2, 4, 3};
  typedef struct {
    logic        wr;
    logic [31:0] dat;
    logic        kn;
    int          acc;
  } ent_t;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [71:0] req_bus = '0;
  logic [33:0] resp [N];
  logic [2:0]  outs [N];
  logic        ao [N];
  logic        dko [N];
  logic [31:0] rdo [N];
  logic [2:0]  oo [N];
  ent_t        mq [N][$];
  int          mwait [N];
  logic [31:0] mmem [N][1024];
  bit          mkn [N][1024];
  int          cyc = 0;
  int          nchk = 0;
  int          nfail = 0;
  int          cnt;
  always #5 clock = ~clock;
  vie_sram_like_slave_if bus [N] ();
  for (genvar k = 0; k < N; k++) begin : g
    assign bus[k].req_bus_i = req_bus;
    assign resp[k] = bus[k].resp_bus_o;
    assign outs[k] = bus[k].outstanding_o;
    vie_sram_like_slave #(.MEM_AW(10), .ADDR_LAT(AL[k]), .DATA_LAT(DL[k]), .DEPTH(DP[k])) u (
      .clock(clock), .reset(reset), .bus(bus[k]));
  end
  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s inst%0d observed %h expected %h", tag, k, obs, exp);
    end
  endtask
  task automatic step(input logic r, input logic rq, input logic w, input logic [3:0] st,
                      input logic [31:0] a, input logic [31:0] d);
    logic        eao, edo;
    logic [31:0] erd;
    logic [9:0]  idx;
    ent_t        h, e;
    @(negedge clock);
    reset   = r;
    req_bus = {rq, w, 2'b10, st, a, d};
    idx     = a[11:2];
    #1;
    for (int k = 0; k < N; k++) begin
      if (!r) begin
        mq[k].delete();
        mwait[k] = 0;
      end
      eao = r && rq && mq[k].size() < DP[k] && mwait[k] >= AL[k];
      edo = mq[k].size() > 0 && (cyc - mq[k][0].acc) >= DL[k];
      erd = 32'h0;
      h.kn = 1'b1;
      if (edo) begin
        h = mq[k][0];
        erd = h.wr ? 32'h0 : h.dat;
        if (h.wr) h.kn = 1'b1;
      end
      ao[k] = resp[k][33]; dko[k] = resp[k][32]; rdo[k] = resp[k][31:0]; oo[k] = outs[k];
      chk("addr_ok", k, ao[k], eao);
      chk("data_ok", k, dko[k], edo);
      chk("outstanding", k, oo[k], mq[k].size());
      if (h.kn) chk("rdata", k, rdo[k], erd);
      if (edo) void'(mq[k].pop_front());
      if (eao) begin
        e.wr = w; e.dat = mmem[k][idx]; e.kn = mkn[k][idx]; e.acc = cyc;
        mq[k].push_back(e);
        if (w) begin
          for (int b = 0; b < 4; b++) if (st[b]) mmem[k][idx][8*b +: 8] = d[8*b +: 8];
          if (st == 4'hf) mkn[k][idx] = 1'b1;
        end
      end
      mwait[k] = (r && rq && !eao) ? mwait[k] + 1 : 0;
    end
    cyc++;
  endtask
  task automatic idle(input int n);
    repeat (n) step(1'b1, 1'b0, 1'b0, 4'h0, $urandom, $urandom);
  endtask
  task automatic rd(input logic [31:0] a);
    step(1'b1, 1'b1, 1'b0, 4'h0, a, $urandom);
  endtask
  initial begin
    logic [31:0] v, a;
    for (int k = 0; k < N; k++) for (int i = 0; i < 1024; i++) mkn[k][i] = 1'b0;
    step(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    for (int i = 0; i < 16; i++) begin
      v = (i == 0) ? 32'h11111111 : (i == 1) ? 32'h22222222 : (i == 2) ? 32'h0 : $urandom;
      a = ($urandom & 32'hfffff003) | (32'(i) << 2);
      repeat (3) step(1'b1, 1'b1, 1'b1, 4'hf, a, v);
    end
    idle(20);
    rd(32'hbfc00000);
    chk("b2b_aok_c0", 0, ao[0], 1'b1);
    chk("b2b_dok_c0", 0, dko[0], 1'b0);
    rd(32'hbfc00004);
    chk("b2b_aok_c1", 0, ao[0], 1'b1);
    chk("b2b_dok_c1", 0, dko[0], 1'b1);
    chk("b2b_rdata_c1", 0, rdo[0], 32'h11111111);
    idle(1);
    chk("b2b_dok_c2", 0, dko[0], 1'b1);
    chk("b2b_rdata_c2", 0, rdo[0], 32'h22222222);
    idle(20);
    rd(32'h0); rd(32'h4); rd(32'h8);
    chk("full_aok_c2", 1, ao[1], 1'b0);
    chk("full_out_c2", 1, oo[1], 3'd2);
    rd(32'h8); rd(32'h8);
    chk("full_dok_c4", 1, dko[1], 1'b1);
    chk("full_aok_c4", 1, ao[1], 1'b0);
    rd(32'h8);
    chk("full_aok_c5", 1, ao[1], 1'b1);
    idle(20);
    step(1'b1, 1'b1, 1'b1, 4'b0101, 32'h8, 32'haabbccdd);
    chk("bw_aok", 0, ao[0], 1'b1);
    rd(32'h8);
    chk("bw_wr_dok", 0, dko[0], 1'b1);
    chk("bw_wr_rdata", 0, rdo[0], 32'h0);
    idle(1);
    chk("bw_rd_dok", 0, dko[0], 1'b1);
    chk("bw_rd_rdata", 0, rdo[0], 32'h00bb00dd);
    idle(20);
    rd(32'h0);
    chk("al_c0", 2, ao[2], 1'b0);
    rd(32'h0); rd(32'h0);
    chk("al_c2", 2, ao[2], 1'b1);
    idle(1);
    rd(32'h0); idle(1); rd(32'h0); rd(32'h0);
    chk("al_restart_c3", 2, ao[2], 1'b0);
    rd(32'h0);
    chk("al_restart_c4", 2, ao[2], 1'b1);
    idle(20);
    cnt = 0;
    rd(32'h0); cnt += dko[3];
    rd(32'h4); cnt += dko[3];
    for (int i = 0; i < 6; i++) begin
      idle(1);
      cnt += dko[3];
    end
    chk("drain_pulses", 3, cnt, 2);
    chk("drain_out", 3, oo[3], 3'd0);
    idle(20);
    rd(32'h0);
    step(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("rst_dok", 0, dko[0], 1'b0);
    chk("rst_out", 0, oo[0], 3'd0);
    idle(3);
    chk("rst_dok_after", 0, dko[0], 1'b0);
    chk("rst_out_after", 0, oo[0], 3'd0);
    rd(32'h0);
    idle(1);
    chk("rst_mem_dok", 0, dko[0], 1'b1);
    chk("rst_mem_rdata", 0, rdo[0], 32'h11111111);
    idle(20);
    repeat (600) begin
      a = ($urandom & 32'hfffff003) | (32'($urandom_range(0, 15)) << 2);
      step($urandom_range(0, 99) != 0, $urandom_range(0, 9) < 6, $urandom_range(0, 2) == 0,
           4'($urandom), a, $urandom);
    end
    idle(20);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
